// File: rtl/fft_pkg.sv
// Shared constants, FSM state encoding and the bit-reversal helper for the
// 32-point FFT sequencer.
package fft_pkg;

   localparam int N     = 32;
   localparam int LOG2N = 5;
   localparam int DW    = 32;
   localparam int CW    = 2 * DW;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      DRAIN,
      UNLOAD
   } state_t;

   // Mirror a 5-bit sample index so the input lands in DIT order.
   function automatic logic [4:0] bitrev5(input logic [4:0] v);
      return {v[0], v[1], v[2], v[3], v[4]};
   endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Stage / butterfly counters for the in-place radix-2 DIT schedule.
// ia, ib and tw are decoded from the current counters, so they describe the
// butterfly being issued in the cycle where advance is high.
module fft_addr_gen
   import fft_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       advance,
   output logic [4:0] ia,
   output logic [4:0] ib,
   output logic [3:0] tw,
   output logic       last_in_stage,
   output logic       last_stage
);

   logic [2:0] stage;
   logic [3:0] k;
   logic [4:0] span;
   logic [4:0] pos;
   logic [4:0] grp;

   // Decode the operand addresses and twiddle index of butterfly k in this stage.
   always_comb begin
      span          = 5'd1 << stage;
      pos           = {1'b0, k} & (span - 5'd1);
      grp           = {1'b0, k} >> stage;
      ia            = (grp << (stage + 3'd1)) + pos;
      ib            = ia + span;
      tw            = 4'(pos << (3'd4 - stage));
      last_in_stage = (k == 4'd15);
      last_stage    = (stage == 3'(LOG2N - 1));
   end

   // Step to the next butterfly, rolling into the next stage and back to stage 0 after the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= '0;
         k     <= '0;
      end else if (advance) begin
         k <= k + 4'd1;
         if (last_in_stage) begin
            stage <= last_stage ? 3'd0 : stage + 3'd1;
         end
      end
   end

endmodule

// File: rtl/fft32_sched_ctrl.sv
// Sequencer for a 32-point radix-2 DIT FFT around one external butterfly.
// Loads real samples in bit-reversed order, runs 5 stages of 16 butterflies
// with in-place write-back, then streams the bins out in natural order.
module fft32_sched_ctrl
   import fft_pkg::*;
#(
   parameter int BF_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          bf_valid,
   output logic [CW-1:0] bf_a,
   output logic [CW-1:0] bf_b,
   output logic [3:0]    bf_tw,
   input  logic [CW-1:0] bf_x,
   input  logic [CW-1:0] bf_y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_data,
   output logic [4:0]    out_idx
);

   localparam int DCW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

   state_t          state;
   logic [4:0]      cnt;
   logic [DCW-1:0]  drain_cnt;
   logic            final_stage;

   logic [CW-1:0]   mem [N];

   logic [4:0]      ia;
   logic [4:0]      ib;
   logic [3:0]      tw;
   logic            last_in_stage;
   logic            last_stage;

   logic [BF_LAT-1:0] wb_v;
   logic [4:0]        wb_ia [BF_LAT];
   logic [4:0]        wb_ib [BF_LAT];

   fft_addr_gen u_addr_gen (
      .clk           (clk),
      .rst_n         (rst_n),
      .advance       (bf_valid),
      .ia            (ia),
      .ib            (ib),
      .tw            (tw),
      .last_in_stage (last_in_stage),
      .last_stage    (last_stage)
   );

   // Operands are read combinationally in the issue cycle so the first butterfly
   // of a stage sees the write-back that completed on the previous edge.
   assign bf_a     = mem[ia];
   assign bf_b     = mem[ib];
   assign bf_tw    = tw;
   assign out_data = mem[out_idx];

   // Main sequencer: state, handshake flags, load/unload counters and the drain timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         in_ready    <= 1'b0;
         bf_valid    <= 1'b0;
         out_valid   <= 1'b0;
         out_idx     <= '0;
         cnt         <= '0;
         drain_cnt   <= '0;
         final_stage <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  in_ready <= 1'b1;
                  cnt      <= '0;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd31) begin
                     state    <= COMPUTE;
                     in_ready <= 1'b0;
                     bf_valid <= 1'b1;
                  end
               end
            end
            COMPUTE: begin
               if (last_in_stage) begin
                  state       <= DRAIN;
                  bf_valid    <= 1'b0;
                  final_stage <= last_stage;
                  drain_cnt   <= '0;
               end
            end
            DRAIN: begin
               if (drain_cnt == DCW'(BF_LAT - 1)) begin
                  if (final_stage) begin
                     state     <= UNLOAD;
                     out_valid <= 1'b1;
                     out_idx   <= '0;
                  end else begin
                     state    <= COMPUTE;
                     bf_valid <= 1'b1;
                  end
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            UNLOAD: begin
               if (out_ready) begin
                  if (out_idx == 5'd31) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     out_idx   <= '0;
                  end else begin
                     out_idx <= out_idx + 5'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Carry each issued address pair alongside the butterfly latency so results land in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_v <= '0;
         for (int i = 0; i < BF_LAT; i++) begin
            wb_ia[i] <= '0;
            wb_ib[i] <= '0;
         end
      end else begin
         wb_v[0]  <= bf_valid;
         wb_ia[0] <= ia;
         wb_ib[0] <= ib;
         for (int i = 1; i < BF_LAT; i++) begin
            wb_v[i]  <= wb_v[i-1];
            wb_ia[i] <= wb_ia[i-1];
            wb_ib[i] <= wb_ib[i-1];
         end
      end
   end

   // Sample buffer: loads come only in LOAD and write-backs only in COMPUTE/DRAIN, so the ports never collide.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         mem[bitrev5(cnt)] <= {in_data, DW'(0)};
      end
      if (wb_v[BF_LAT-1]) begin
         mem[wb_ia[BF_LAT-1]] <= bf_x;
         mem[wb_ib[BF_LAT-1]] <= bf_y;
      end
   end

endmodule
